// File: rtl/iobs_pwfifo.sv
// ---------------------------------------------------------------------------
// iobs_pwfifo -- posted-write buffer between the FSB slave and the IOB master.
//
// Queues up to DEPTH I/O writes and drains them in order through the
// IOREQ/IOACT/IODONE handshake. Non-posted requests (reads, IACK) are granted
// only once the queue is empty and the IOB is idle, so program order holds.
//
// Optional feature (compile-time macro PWFIFO_COALESCE_EN):
//   A write to the same word address as the newest queued entry merges into
//   it byte-wise instead of allocating a slot. Without the macro no address
//   comparator is built.
//
// Ports:
//   CLK, RES                FSB clock, synchronous active-high reset
//   WrReq/WrA/WrD/WrL/WrU   posted-write request and payload (held to WrAck)
//   WrAck                   one-cycle pulse: the write was captured
//   RdReq / RdGrant         non-posted request / queue drained and IOB idle
//   IOREQ/IORW/IOA/IOD/IOL/IOU  head-entry request to the IOB master
//   IOACT / IODONE / BERRin IOB cycle started / finished / bus error
//   ErrClr / ErrSticky      clear / sticky posted-write bus-error flag
//   Full / Empty / Level    occupancy status
// ---------------------------------------------------------------------------
module iobs_pwfifo #(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned ADDR_W = 23,
    parameter  int unsigned DATA_W = 16,
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              WrReq,
    input  logic [ADDR_W-1:0] WrA,
    input  logic [DATA_W-1:0] WrD,
    input  logic              WrL,
    input  logic              WrU,
    output logic              WrAck,
    input  logic              RdReq,
    output logic              RdGrant,
    output logic              IOREQ,
    output logic              IORW,
    output logic [ADDR_W-1:0] IOA,
    output logic [DATA_W-1:0] IOD,
    output logic              IOL,
    output logic              IOU,
    input  logic              IOACT,
    input  logic              IODONE,
    input  logic              BERRin,
    input  logic              ErrClr,
    output logic              ErrSticky,
    output logic              Full,
    output logic              Empty,
    output logic [PTR_W:0]    Level
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACT  = 2'd2
    } stateT;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              l;
        logic              u;
    } entryT;

    entryT            mem [DEPTH];
    stateT            state;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] newestPtr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   countNext;
    logic             reqValid;
    logic             alloc;
    logic             merge;
    logic             pop;
    logic             nextIdle;
    entryT            wrEntry;
    entryT            headEntry;
`ifdef PWFIFO_COALESCE_EN
    entryT            mergedEntry;
`endif

    // Writes always go out as writes.
    assign IORW      = 1'b0;
    assign Level     = count;
    assign newestPtr = wptr - PTR_W'(1);

    // Push/pop decisions and next occupancy.
    always_comb begin
        wrEntry   = '{a: WrA, d: WrD, l: WrL, u: WrU};
        headEntry = mem[rptr];
        // The cycle after an ack still sees the old request held high.
        reqValid  = WrReq && !WrAck;
        pop       = (state == ST_ACT) && IODONE;
        merge     = 1'b0;
`ifdef PWFIFO_COALESCE_EN
        mergedEntry = mem[newestPtr];
        if (WrL) mergedEntry.d[7:0]        = WrD[7:0];
        if (WrU) mergedEntry.d[DATA_W-1:8] = WrD[DATA_W-1:8];
        mergedEntry.l = mergedEntry.l | WrL;
        mergedEntry.u = mergedEntry.u | WrU;
        // The head is frozen once presented to the IOB.
        merge = reqValid && (count != '0) && (mem[newestPtr].a == WrA)
                && !((count == CNT_ONE) && (state != ST_IDLE));
        // Merging into the head while idle must be visible as it is issued.
        if (merge && (newestPtr == rptr)) headEntry = mergedEntry;
`endif
        // Full check uses the registered count: no fall-through on a pop.
        alloc     = reqValid && !merge && (count != CNT_FULL);
        countNext = count;
        if (alloc && !pop) begin
            countNext = count + CNT_ONE;
        end else if (pop && !alloc) begin
            countNext = count - CNT_ONE;
        end
        nextIdle  = pop || ((state == ST_IDLE) && (count == '0));
    end

    // Entry storage; contents need no reset, occupancy is tracked by count.
    always_ff @(posedge CLK) begin
        if (!RES) begin
            if (alloc) mem[wptr] <= wrEntry;
`ifdef PWFIFO_COALESCE_EN
            if (merge) mem[newestPtr] <= mergedEntry;
`endif
        end
    end

    // Pointers, status flags and drain FSM.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state     <= ST_IDLE;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            WrAck     <= 1'b0;
            RdGrant   <= 1'b0;
            IOREQ     <= 1'b0;
            IOA       <= '0;
            IOD       <= '0;
            IOL       <= 1'b0;
            IOU       <= 1'b0;
            ErrSticky <= 1'b0;
            Full      <= 1'b0;
            Empty     <= 1'b1;
        end else begin
            WrAck   <= alloc || merge;
            if (alloc) wptr <= wptr + PTR_W'(1);
            if (pop)   rptr <= rptr + PTR_W'(1);
            count   <= countNext;
            Full    <= (countNext == CNT_FULL);
            Empty   <= (countNext == '0);
            RdGrant <= nextIdle && (countNext == '0) && RdReq && !WrReq;

            // A new error wins over a simultaneous clear.
            if (pop && BERRin) begin
                ErrSticky <= 1'b1;
            end else if (ErrClr) begin
                ErrSticky <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state <= ST_REQ;
                        IOREQ <= 1'b1;
                        IOA   <= headEntry.a;
                        IOD   <= headEntry.d;
                        IOL   <= headEntry.l;
                        IOU   <= headEntry.u;
                    end
                end
                ST_REQ: begin
                    if (IOACT) begin
                        state <= ST_ACT;
                        IOREQ <= 1'b0;
                    end
                end
                ST_ACT: begin
                    // Head is popped even on a bus error; the error is flagged.
                    if (IODONE) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    IOREQ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iobs_pwfifo.sv
// ---------------------------------------------------------------------------
// tb_iobs_pwfifo -- bench for iobs_pwfifo (DEPTH=4, 23-bit address, 16-bit data).
// A queue-based reference model tracks the buffer contents and the IOB
// handshake phase; a compare process checks every output after every edge.
// Directed scenarios pin the model with literal expectations, then a long
// randomized run exercises arbitrary input interleavings. Build with
// +define+PWFIFO_COALESCE_EN to include the merge scenario.
// ---------------------------------------------------------------------------
module tb_iobs_pwfifo;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        WrReq = 1'b0;
    logic [22:0] WrA = '0;
    logic [15:0] WrD = '0;
    logic        WrL = 1'b0;
    logic        WrU = 1'b0;
    logic        WrAck;
    logic        RdReq = 1'b0;
    logic        RdGrant;
    logic        IOREQ;
    logic        IORW;
    logic [22:0] IOA;
    logic [15:0] IOD;
    logic        IOL;
    logic        IOU;
    logic        IOACT = 1'b0;
    logic        IODONE = 1'b0;
    logic        BERRin = 1'b0;
    logic        ErrClr = 1'b0;
    logic        ErrSticky;
    logic        Full;
    logic        Empty;
    logic [2:0]  Level;

    int nTests = 0;
    int nFail  = 0;

    iobs_pwfifo #(.DEPTH(4), .ADDR_W(23), .DATA_W(16)) dut (
        .CLK(CLK), .RES(RES),
        .WrReq(WrReq), .WrA(WrA), .WrD(WrD), .WrL(WrL), .WrU(WrU), .WrAck(WrAck),
        .RdReq(RdReq), .RdGrant(RdGrant),
        .IOREQ(IOREQ), .IORW(IORW), .IOA(IOA), .IOD(IOD), .IOL(IOL), .IOU(IOU),
        .IOACT(IOACT), .IODONE(IODONE), .BERRin(BERRin),
        .ErrClr(ErrClr), .ErrSticky(ErrSticky),
        .Full(Full), .Empty(Empty), .Level(Level)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [22:0] a;
        logic [15:0] d;
        logic        l;
        logic        u;
    } entT;

    entT         q[$];
    int          phase = 0;        // 0 idle, 1 presented, 2 IOB cycle running
    logic        mWrAck = 1'b0;
    logic        mRdGrant = 1'b0;
    logic        mIoreq = 1'b0;
    logic [22:0] mIoa = '0;
    logic [15:0] mIod = '0;
    logic        mIol = 1'b0;
    logic        mIou = 1'b0;
    logic        mErr = 1'b0;

    task automatic modelStep();
        int  oldSize;
        int  nextPhase;
        bit  ok;
        bit  mrg;
        bit  alc;
        bit  popNow;
        entT e;
        if (RES) begin
            q.delete();
            phase = 0;
            mWrAck = 1'b0; mRdGrant = 1'b0; mIoreq = 1'b0;
            mIoa = '0; mIod = '0; mIol = 1'b0; mIou = 1'b0; mErr = 1'b0;
            return;
        end
        oldSize = q.size();
        ok      = WrReq && !mWrAck;
        popNow  = (phase == 2) && IODONE;
        mrg     = 1'b0;
`ifdef PWFIFO_COALESCE_EN
        if (ok && oldSize > 0 && q[oldSize-1].a == WrA && !(oldSize == 1 && phase != 0))
            mrg = 1'b1;
`endif
        alc = ok && !mrg && (oldSize < DEPTH);
        nextPhase = phase;
        case (phase)
            0:       if (oldSize > 0) nextPhase = 1;
            1:       if (IOACT)       nextPhase = 2;
            default: if (IODONE)      nextPhase = 0;
        endcase
        if (mrg) begin
            e = q[oldSize-1];
            if (WrL) e.d[7:0]  = WrD[7:0];
            if (WrU) e.d[15:8] = WrD[15:8];
            e.l = e.l | WrL;
            e.u = e.u | WrU;
            q[oldSize-1] = e;
        end
        if (phase == 0 && nextPhase == 1) begin
            mIoa = q[0].a; mIod = q[0].d; mIol = q[0].l; mIou = q[0].u;
        end
        if (popNow) q.delete(0);
        if (alc) begin
            e.a = WrA; e.d = WrD; e.l = WrL; e.u = WrU;
            q.push_back(e);
        end
        if (popNow && BERRin) mErr = 1'b1;
        else if (ErrClr)      mErr = 1'b0;
        phase    = nextPhase;
        mIoreq   = (phase == 1);
        mWrAck   = alc || mrg;
        mRdGrant = (phase == 0) && (q.size() == 0) && RdReq && !WrReq;
    endtask

    task automatic compareAll();
        chk("WrAck",     32'(WrAck),     32'(mWrAck));
        chk("RdGrant",   32'(RdGrant),   32'(mRdGrant));
        chk("IOREQ",     32'(IOREQ),     32'(mIoreq));
        chk("IORW",      32'(IORW),      32'(0));
        chk("ErrSticky", 32'(ErrSticky), 32'(mErr));
        chk("Level",     32'(Level),     32'(q.size()));
        chk("Full",      32'(Full),      32'(q.size() == DEPTH));
        chk("Empty",     32'(Empty),     32'(q.size() == 0));
        if (mIoreq) begin
            chk("IOA", 32'(IOA), 32'(mIoa));
            chk("IOD", 32'(IOD), 32'(mIod));
            chk("IOL", 32'(IOL), 32'(mIol));
            chk("IOU", 32'(IOU), 32'(mIou));
        end
    endtask

    // Model advances on the edge with the inputs the DUT sampled; outputs
    // are compared 1 time unit later.
    always @(posedge CLK) begin
        modelStep();
        #1;
        compareAll();
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change 2 units after the edge, after the compare has sampled.
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic doWrite(input logic [22:0] a, input logic [15:0] d,
                           input logic l, input logic u);
        int waited;
        WrA = a; WrD = d; WrL = l; WrU = u; WrReq = 1'b1;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!WrAck && waited < 50);
        WrReq = 1'b0;
        if (!WrAck) chk("wrack_timeout", 32'(WrAck), 32'(1));
    endtask

    task automatic waitIoreq();
        for (int i = 0; i < 50 && !IOREQ; i++) step();
        if (!IOREQ) chk("ioreq_timeout", 32'(IOREQ), 32'(1));
    endtask

    task automatic serve(input logic berr, input logic clr,
                         output logic [22:0] aSeen, output logic [15:0] dSeen);
        waitIoreq();
        aSeen = IOA;
        dSeen = IOD;
        IOACT = 1'b1;
        step();
        IOACT = 1'b0;
        IODONE = 1'b1; BERRin = berr; ErrClr = clr;
        step();
        IODONE = 1'b0; BERRin = 1'b0; ErrClr = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [22:0] a;
        logic [15:0] d;
        logic [22:0] expA [4];

        RES = 1'b1;
        repeat (3) step();
        chk("rst_empty", 32'(Empty),   32'(1));
        chk("rst_level", 32'(Level),   32'(0));
        chk("rst_ioreq", 32'(IOREQ),   32'(0));
        chk("rst_wrack", 32'(WrAck),   32'(0));
        chk("rst_ioa",   32'(IOA),     32'(0));
        RES = 1'b0;
        step();

        // Single write: ack on the capture edge, request one edge later.
        WrA = 23'h7FFFF0; WrD = 16'hA55A; WrL = 1'b1; WrU = 1'b1; WrReq = 1'b1;
        step();
        chk("single_wrack", 32'(WrAck), 32'(1));
        chk("single_ioreq_early", 32'(IOREQ), 32'(0));
        WrReq = 1'b0;
        step();
        chk("single_ioreq", 32'(IOREQ), 32'(1));
        chk("single_ioa",   32'(IOA),   32'h7FFFF0);
        chk("single_iod",   32'(IOD),   32'hA55A);
        IOACT = 1'b1; step(); IOACT = 1'b0;
        chk("single_act_ioreq", 32'(IOREQ), 32'(0));
        IODONE = 1'b1; step(); IODONE = 1'b0;
        chk("single_empty", 32'(Empty), 32'(1));
        chk("single_level", 32'(Level), 32'(0));

        // Fill to DEPTH with the IOB stalled.
        for (int i = 0; i < 4; i++) doWrite(23'(i + 1), 16'(16'h1000 + i), 1'b1, 1'b1);
        chk("fill_full",  32'(Full),  32'(1));
        chk("fill_level", 32'(Level), 32'(4));
        WrA = 23'd5; WrD = 16'h1004; WrReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_noack", 32'(WrAck), 32'(0));
        end
        waitIoreq();
        IOACT = 1'b1; step(); IOACT = 1'b0;
        IODONE = 1'b1; step(); IODONE = 1'b0;
        chk("ack_at_pop", 32'(WrAck), 32'(0));
        step();
        chk("ack_after_pop", 32'(WrAck), 32'(1));
        WrReq = 1'b0;
        expA[0] = 23'd2; expA[1] = 23'd3; expA[2] = 23'd4; expA[3] = 23'd5;
        for (int i = 0; i < 4; i++) begin
            serve(1'b0, 1'b0, a, d);
            chk("drain_order", 32'(a), 32'(expA[i]));
        end
        chk("drain_empty", 32'(Empty), 32'(1));

        // Read ordering behind two posted writes.
        doWrite(23'h0300, 16'h0001, 1'b1, 1'b0);
        doWrite(23'h0301, 16'h0002, 1'b0, 1'b1);
        RdReq = 1'b1;
        step();
        chk("rd_hold0", 32'(RdGrant), 32'(0));
        serve(1'b0, 1'b0, a, d);
        chk("rd_hold1", 32'(RdGrant), 32'(0));
        serve(1'b0, 1'b0, a, d);
        chk("rd_grant", 32'(RdGrant), 32'(1));
        RdReq = 1'b0;
        step();

        // Bus error: flagged, next entry still issued; clear; set beats clear.
        doWrite(23'h0400, 16'hBEEF, 1'b1, 1'b1);
        doWrite(23'h0401, 16'hCAFE, 1'b1, 1'b1);
        serve(1'b1, 1'b0, a, d);
        chk("berr_sticky", 32'(ErrSticky), 32'(1));
        serve(1'b0, 1'b0, a, d);
        chk("berr_next_a", 32'(a), 32'h0401);
        chk("berr_next_d", 32'(d), 32'hCAFE);
        chk("berr_hold",   32'(ErrSticky), 32'(1));
        ErrClr = 1'b1; step(); ErrClr = 1'b0;
        chk("berr_clr", 32'(ErrSticky), 32'(0));
        doWrite(23'h0402, 16'h0BAD, 1'b1, 1'b1);
        serve(1'b1, 1'b1, a, d);
        chk("berr_set_wins", 32'(ErrSticky), 32'(1));

        // Reset in the middle of an IOB cycle with three entries queued.
        doWrite(23'h0010, 16'h0010, 1'b1, 1'b1);
        doWrite(23'h0011, 16'h0011, 1'b1, 1'b1);
        doWrite(23'h0012, 16'h0012, 1'b1, 1'b1);
        waitIoreq();
        IOACT = 1'b1; step(); IOACT = 1'b0;
        chk("pre_rst_level", 32'(Level), 32'(3));
        RES = 1'b1; step(); RES = 1'b0;
        chk("midrst_ioreq", 32'(IOREQ),     32'(0));
        chk("midrst_level", 32'(Level),     32'(0));
        chk("midrst_empty", 32'(Empty),     32'(1));
        chk("midrst_err",   32'(ErrSticky), 32'(0));
        doWrite(23'h0222, 16'h5678, 1'b1, 1'b1);
        serve(1'b0, 1'b0, a, d);
        chk("post_rst_a", 32'(a), 32'h0222);
        chk("post_rst_d", 32'(d), 32'h5678);

`ifdef PWFIFO_COALESCE_EN
        // Byte merge into the newest entry while the head is presented.
        doWrite(23'h0100, 16'h0000, 1'b1, 1'b1);
        waitIoreq();
        doWrite(23'h580000, 16'h12AB, 1'b0, 1'b1);
        chk("co_level1", 32'(Level), 32'(2));
        doWrite(23'h580000, 16'hCD34, 1'b1, 1'b0);
        chk("co_level2", 32'(Level), 32'(2));
        serve(1'b0, 1'b0, a, d);
        waitIoreq();
        chk("co_ioa", 32'(IOA), 32'h580000);
        chk("co_iod", 32'(IOD), 32'h1234);
        chk("co_iol", 32'(IOL), 32'(1));
        chk("co_iou", 32'(IOU), 32'(1));
        serve(1'b0, 1'b0, a, d);
`endif

        // Randomized interleavings, checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            WrReq = ($urandom % 3) != 0;
            case ($urandom % 4)
                0:       WrA = 23'h580000;
                1:       WrA = 23'h580001;
                2:       WrA = 23'h7FFFF0;
                default: WrA = 23'($urandom);
            endcase
            WrD    = 16'($urandom);
            WrL    = ($urandom % 4) != 0;
            WrU    = ($urandom % 4) != 0;
            RdReq  = ($urandom % 2) != 0;
            IOACT  = ($urandom % 3) == 0;
            IODONE = ($urandom % 3) == 0;
            BERRin = ($urandom % 4) == 0;
            ErrClr = ($urandom % 8) == 0;
            RES    = ($urandom % 300) == 0;
            step();
        end

        WrReq = 1'b0; RdReq = 1'b0; IOACT = 1'b0; IODONE = 1'b0;
        BERRin = 1'b0; ErrClr = 1'b0; RES = 1'b1;
        step();
        RES = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
